// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ALU ops and shifts, plus a 16-iteration shift-add multiplier.
// The result, wr_en and the {C,L,F,Z,N} flags are registered on the completion edge.
module alu_exec_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic             shift_en,
  input  logic             shift_type,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic             done,
  output logic             busy,
  output logic [4:0]       flags
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_MUL  = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_ADDU = 4'b0101;
  localparam logic [3:0] OP_SUBU = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1000;
  localparam logic [3:0] OP_MOV  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_LUI  = 4'b1011;

  // Bit positions inside flags = {C,L,F,Z,N}.
  localparam int FC = 4;
  localparam int FL = 3;
  localparam int FF = 2;
  localparam int FZ = 1;
  localparam int FN = 0;

  logic             state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic [4:0]       shamt;
  logic [4:0]       rmag;
  logic [WIDTH-1:0] op_res;
  logic             op_wr;
  logic [4:0]       op_flags;
  logic [WIDTH-1:0] mul_add;
  logic [WIDTH-1:0] acc_next;
  logic             is_mul;

  assign busy    = (state == S_MUL);
  assign is_mul  = !shift_en && (alu_ctrl == OP_MUL);
  assign sum     = {1'b0, a} + {1'b0, b};
  // The extra top bit of the unsigned difference is the borrow, i.e. a < b unsigned.
  assign diff    = {1'b0, a} - {1'b0, b};
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign shamt   = b[4:0];
  assign rmag    = -shamt;
  assign mul_add = mplier[cnt] ? (mcand << cnt) : '0;
  assign acc_next = acc + mul_add;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    op_res   = '0;
    op_wr    = 1'b0;
    op_flags = flags;
    if (shift_en) begin
      op_wr = 1'b1;
      if (!shamt[4])
        op_res = a << shamt[3:0];
      else if (shift_type)
        op_res = $signed(a) >>> rmag;
      else
        op_res = a >> rmag;
    end else begin
      case (alu_ctrl)
        OP_ADD: begin
          op_res = sum[WIDTH-1:0];  op_wr = 1'b1;
          op_flags[FC] = sum[WIDTH];
          op_flags[FF] = add_ovf;
        end
        OP_AND:  begin op_res = a & b; op_wr = 1'b1; end
        OP_OR:   begin op_res = a | b; op_wr = 1'b1; end
        OP_XOR:  begin op_res = a ^ b; op_wr = 1'b1; end
        OP_SUB: begin
          op_res = diff[WIDTH-1:0]; op_wr = 1'b1;
          op_flags[FC] = diff[WIDTH];
          op_flags[FF] = sub_ovf;
        end
        OP_ADDU: begin op_res = sum[WIDTH-1:0];  op_wr = 1'b1; op_flags[FC] = sum[WIDTH];  end
        OP_SUBU: begin op_res = diff[WIDTH-1:0]; op_wr = 1'b1; op_flags[FC] = diff[WIDTH]; end
        OP_NOT:  begin op_res = ~b; op_wr = 1'b1; end
        OP_CMP: begin
          op_flags[FZ] = (a == b);
          op_flags[FL] = diff[WIDTH];
          op_flags[FN] = $signed(a) < $signed(b);
        end
        OP_MOV:  begin op_res = b; op_wr = 1'b1; end
        OP_LUI:  begin op_res = {b[7:0], 8'h00}; op_wr = 1'b1; end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      result <= '0;
      flags  <= '0;
      done   <= 1'b0;
      wr_en  <= 1'b0;
    end else begin
      done  <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_mul) begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
              state  <= S_MUL;
            end else begin
              result <= op_res;
              wr_en  <= op_wr;
              flags  <= op_flags;
              done   <= 1'b1;
            end
          end
        end
        default: begin
          acc <= acc_next;
          cnt <= cnt + 4'd1;
          // Last iteration: publish the final sum directly; flags are not touched by MUL.
          if (cnt == 4'd15) begin
            result <= acc_next;
            done   <= 1'b1;
            wr_en  <= 1'b1;
            state  <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit; expected values are hand-computed constants.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  alu_ctrl;
  logic        shift_en;
  logic        shift_type;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        wr_en;
  logic        done;
  logic        busy;
  logic [4:0]  flags;

  int n_cmp = 0;
  int n_err = 0;

  alu_exec_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
    .shift_en(shift_en), .shift_type(shift_type), .a(a), .b(b),
    .result(result), .wr_en(wr_en), .done(done), .busy(busy), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request at the falling edge, let the next rising edge sample it, then drop start.
  task automatic issue(input logic [3:0] ctrl, input logic sh_en, input logic sh_type,
                       input logic [15:0] va, input logic [15:0] vb);
    @(negedge clk);
    alu_ctrl = ctrl; shift_en = sh_en; shift_type = sh_type; a = va; b = vb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic expect_op(input string tag, input logic [15:0] res, input logic wr, input logic [4:0] fl);
    check({tag, ".done"},   32'(done),   32'd1);
    check({tag, ".result"}, 32'(result), 32'(res));
    check({tag, ".wr_en"},  32'(wr_en),  32'(wr));
    check({tag, ".flags"},  32'(flags),  32'(fl));
  endtask

  // Runs cycles after a MUL was accepted until done; returns the edge count and busy-cycle count.
  task automatic wait_mul(input logic inject_add, output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cycles++;
      if (inject_add && edges == 3) begin
        alu_ctrl = 4'b0000; shift_en = 1'b0; a = 16'h0001; b = 16'h0001; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    start = 1'b0;
  endtask

  int edges;
  int busy_cycles;
  int done_seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_ctrl = '0; shift_en = 1'b0; shift_type = 1'b0; a = '0; b = '0;
    #22;
    check("rst.result", 32'(result), 32'h0);
    check("rst.flags",  32'(flags),  32'h0);
    check("rst.done",   32'(done),   32'h0);
    check("rst.busy",   32'(busy),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("idle.no_done", 32'(done_seen), 32'd0);

    // ADD overflow then ADDU carry; C=bit4 L=bit3 F=bit2 Z=bit1 N=bit0.
    issue(4'b0000, 1'b0, 1'b0, 16'h7FFF, 16'h0001);
    expect_op("add", 16'h8000, 1'b1, 5'b00100);
    issue(4'b0101, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
    expect_op("addu", 16'h0000, 1'b1, 5'b10100);
    @(posedge clk); #1;
    check("addu.done_once", 32'(done), 32'd0);

    issue(4'b1000, 1'b0, 1'b0, 16'h0001, 16'hFFFF);
    expect_op("cmp_lt", 16'h0000, 1'b0, 5'b11100);
    issue(4'b1000, 1'b0, 1'b0, 16'h1234, 16'h1234);
    expect_op("cmp_eq", 16'h0000, 1'b0, 5'b10110);

    // MUL with an ADD request injected while busy; it must be dropped.
    issue(4'b1010, 1'b0, 1'b0, 16'h0123, 16'h0045);
    wait_mul(1'b1, edges, busy_cycles);
    check("mul.latency_edges", 32'(edges), 32'd16);
    check("mul.busy_cycles", 32'(busy_cycles), 32'd16);
    check("mul.busy_at_done", 32'(busy), 32'd0);
    expect_op("mul", 16'h4E6F, 1'b1, 5'b10110);
    @(posedge clk); #1;
    check("mul.no_queued_done", 32'(done), 32'd0);
    check("mul.result_hold", 32'(result), 32'h4E6F);

    // Shifts: flags must stay at 10110; requests issued back-to-back with each done.
    issue(4'b0000, 1'b1, 1'b1, 16'h8000, 16'h001F);
    expect_op("sra1", 16'hC000, 1'b1, 5'b10110);
    issue(4'b0000, 1'b1, 1'b0, 16'h8000, 16'h001F);
    expect_op("srl1", 16'h4000, 1'b1, 5'b10110);
    issue(4'b0000, 1'b1, 1'b0, 16'h8000, 16'h0004);
    expect_op("sll4_out", 16'h0000, 1'b1, 5'b10110);
    issue(4'b0000, 1'b1, 1'b0, 16'h0001, 16'h0004);
    expect_op("sll4", 16'h0010, 1'b1, 5'b10110);
    issue(4'b0000, 1'b1, 1'b1, 16'h8000, 16'h0010);
    expect_op("sra16", 16'hFFFF, 1'b1, 5'b10110);
    issue(4'b0000, 1'b1, 1'b0, 16'h8000, 16'h0010);
    expect_op("srl16", 16'h0000, 1'b1, 5'b10110);

    // SUB borrow clears F; undefined code writes nothing; LUI leaves a nonzero result.
    issue(4'b0100, 1'b0, 1'b0, 16'h0003, 16'h0005);
    expect_op("sub", 16'hFFFE, 1'b1, 5'b10010);
    issue(4'b1100, 1'b0, 1'b0, 16'h1111, 16'h2222);
    expect_op("undef", 16'h0000, 1'b0, 5'b10010);
    issue(4'b1011, 1'b0, 1'b0, 16'h0000, 16'h00AB);
    expect_op("lui", 16'hAB00, 1'b1, 5'b10010);

    // Async reset during MUL iteration 8.
    issue(4'b1010, 1'b0, 1'b0, 16'h00FF, 16'h00FF);
    repeat (8) begin @(posedge clk); #1; end
    check("mid_mul.busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.busy",   32'(busy),   32'd0);
    check("arst.done",   32'(done),   32'd0);
    check("arst.wr_en",  32'(wr_en),  32'd0);
    check("arst.result", 32'(result), 32'h0);
    check("arst.flags",  32'(flags),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("arst.no_done", 32'(done_seen), 32'd0);

    issue(4'b1010, 1'b0, 1'b0, 16'h0003, 16'h0005);
    wait_mul(1'b0, edges, busy_cycles);
    check("mul2.latency_edges", 32'(edges), 32'd16);
    expect_op("mul2", 16'h000F, 1'b1, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
